// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of pc_sequencer: redirect requests and stall inputs in,
// fetch address and status out. The slave modport is the sequencer itself.
interface pc_sequencer_if #(
   parameter int INST_MEM_WIDTH = 14,
   parameter int NUM_SRC        = 4
);
   logic                                enable;
   logic                                fetch_ready;
   logic [NUM_SRC-1:0]                  redirect_valid;
   logic [NUM_SRC*INST_MEM_WIDTH-1:0]   redirect_pc;
   logic                                call;
   logic                                ret;
   logic [INST_MEM_WIDTH-1:0]           pc;
   logic                                pc_valid;
   logic                                redirect_pending;
   logic                                ras_empty;

   modport master (
      output enable, fetch_ready, redirect_valid, redirect_pc, call, ret,
      input  pc, pc_valid, redirect_pending, ras_empty
   );

   modport slave (
      input  enable, fetch_ready, redirect_valid, redirect_pc, call, ret,
      output pc, pc_valid, redirect_pending, ras_empty
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: prioritised redirects, stall-safe redirect capture, sequential increment.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; otherwise call/ret are ignored.
module pc_sequencer #(
   parameter int                          INST_MEM_WIDTH = 14,
   parameter int                          NUM_SRC        = 4,
   parameter int                          RAS_DEPTH      = 8,
   parameter logic [INST_MEM_WIDTH-1:0]   RESET_PC       = '0
) (
   input logic           CLK,
   input logic           reset_n,
   pc_sequencer_if.slave bus
);
   localparam int             W      = INST_MEM_WIDTH;
   localparam logic [W-1:0]   PC_ONE = W'(1);

   logic           advance;
   logic           any_redirect;
   logic           ras_hit;
   logic [W-1:0]   sel_pc;
   logic [W-1:0]   pc_q;
   logic [W-1:0]   pc_next;
   logic [W-1:0]   pc_inc;
   logic [W-1:0]   pend_pc;
   logic [W-1:0]   pend_pc_next;
   logic [W-1:0]   ras_top;
   logic           pc_valid_q;
   logic           pend_valid;
   logic           pend_valid_next;

   assign advance      = bus.enable & bus.fetch_ready;
   assign any_redirect = |bus.redirect_valid;
   assign pc_inc       = pc_q + PC_ONE;

   // Scan from the lowest-priority source upwards so source 0 is written last and wins.
   always_comb begin
      sel_pc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (bus.redirect_valid[i]) sel_pc = bus.redirect_pc[i*W +: W];
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      pc_next         = pc_q;
      pend_valid_next = pend_valid;
      pend_pc_next    = pend_pc;
      if (advance) begin
         pend_valid_next = 1'b0;
         if (any_redirect)    pc_next = sel_pc;
         else if (pend_valid) pc_next = pend_pc;
         else if (ras_hit)    pc_next = ras_top;
         else                 pc_next = pc_inc;
      end else if (any_redirect) begin
         pend_valid_next = 1'b1;
         pend_pc_next    = sel_pc;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else begin
         pc_q       <= pc_next;
         pc_valid_q <= 1'b1;
         pend_valid <= pend_valid_next;
         pend_pc    <= pend_pc_next;
      end
   end

   assign bus.pc               = pc_q;
   assign bus.pc_valid         = pc_valid_q;
   assign bus.redirect_pending = pend_valid;

`ifdef PC_SEQUENCER_RAS_EN
   localparam int              PW       = $clog2(RAS_DEPTH);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]     CNT_FULL = (PW+1)'(RAS_DEPTH);

   logic [W-1:0]    ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   ptr_popped;
   logic [PW:0]     ras_count;
   logic [PW:0]     cnt_popped;
   logic            ras_upd;
   logic            ras_pop;
   logic            ras_push;

   // Redirect or pending-consume cycles fetch down a wrong path, so their call/ret are dropped.
   assign ras_upd    = advance & ~any_redirect & ~pend_valid;
   assign ras_hit    = bus.ret & (ras_count != '0);
   assign ras_pop    = ras_upd & ras_hit;
   assign ras_push   = ras_upd & bus.call;
   assign ras_top    = ras_mem[ras_ptr - PTR_ONE];
   assign ptr_popped = ras_pop ? ras_ptr - PTR_ONE : ras_ptr;
   assign cnt_popped = ras_pop ? ras_count - CNT_ONE : ras_count;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (ras_push) begin
         ras_ptr   <= ptr_popped + PTR_ONE;
         ras_count <= (cnt_popped == CNT_FULL) ? CNT_FULL : cnt_popped + CNT_ONE;
      end else begin
         ras_ptr   <= ptr_popped;
         ras_count <= cnt_popped;
      end
   end

   // NOTE: stack storage is deliberately not reset; the count alone decides which entries are live.
   always_ff @(posedge CLK) begin
      if (ras_push) ras_mem[ptr_popped] <= pc_inc;
   end

   assign bus.ras_empty = (ras_count == '0);
`else
   logic unused_ras_in;

   assign unused_ras_in = bus.call ^ bus.ret;
   assign ras_hit       = 1'b0;
   assign ras_top       = '0;
   assign bus.ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-cycle vectors plus hand-written RAS,
// stall and async-reset sequences. RAS expectations follow PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;
   localparam int W = 14;
   localparam int N = 4;

   typedef struct {
      string            name;
      logic             en;
      logic             rdy;
      logic [N-1:0]     rv;
      logic [N*W-1:0]   rpc;
      logic             call;
      logic             ret;
      logic [W-1:0]     exp_pc;
      logic             exp_pend;
   } vec_t;

   logic CLK;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   pc_sequencer_if #(.INST_MEM_WIDTH(W), .NUM_SRC(N)) bus ();

   pc_sequencer #(
      .INST_MEM_WIDTH(W),
      .NUM_SRC(N),
      .RAS_DEPTH(8),
      .RESET_PC(14'h0000)
   ) dut (
      .CLK(CLK),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
      $fatal(1, "timeout");
   end

   function automatic logic [N*W-1:0] pk(input logic [W-1:0] s0, s1, s2, s3);
      return {s3, s2, s1, s0};
   endfunction

   function automatic vec_t mk(input string n, input logic en, rdy, input logic [N-1:0] rv,
                               input logic [N*W-1:0] rpc, input logic c, r,
                               input logic [W-1:0] epc, input logic epend);
      vec_t v;
      v.name = n; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.call = c; v.ret = r; v.exp_pc = epc; v.exp_pend = epend;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic en, rdy, input logic [N-1:0] rv, input logic [N*W-1:0] rpc,
                        input logic c, r);
      bus.enable         = en;
      bus.fetch_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.call           = c;
      bus.ret            = r;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One advancing cycle with the given call/ret, no redirects; checks pc and ras_empty.
   task automatic adv(input string name, input logic c, r, input logic [W-1:0] epc, input logic eempty);
      drive(1'b1, 1'b1, 4'b0000, pk(14'h0, 14'h0, 14'h0, 14'h0), c, r);
      step();
      check({name, ".pc"}, bus.pc, epc);
      check({name, ".ras_empty"}, bus.ras_empty, eempty);
   endtask

   task automatic jump(input string name, input logic [W-1:0] tgt, input logic eempty);
      drive(1'b1, 1'b1, 4'b0010, pk(14'h0, tgt, 14'h0, 14'h0), 1'b0, 1'b0);
      step();
      check({name, ".pc"}, bus.pc, tgt);
      check({name, ".ras_empty"}, bus.ras_empty, eempty);
   endtask

   vec_t          vecs [20];
   logic [W-1:0]  e;

   initial begin
      reset_n = 1'b0;
      drive(1'b1, 1'b1, 4'b0000, pk(14'h0, 14'h0, 14'h0, 14'h0), 1'b0, 1'b0);

      vecs[0]  = mk("inc1",          1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b0);
      vecs[1]  = mk("inc2_ignore",   1'b1, 1'b1, 4'b0000, pk(14'h155, 14'h2AA, 14'h0F0, 14'h3C3), 1'b0, 1'b0, 14'h0002, 1'b0);
      vecs[2]  = mk("inc3",          1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0003, 1'b0);
      vecs[3]  = mk("redir_src3",    1'b1, 1'b1, 4'b1000, pk(14'h000, 14'h000, 14'h000, 14'h3FFF), 1'b0, 1'b0, 14'h3FFF, 1'b0);
      vecs[4]  = mk("wrap",          1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0000, 1'b0);
      vecs[5]  = mk("after_wrap",    1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b0);
      vecs[6]  = mk("stall_src1",    1'b1, 1'b0, 4'b0010, pk(14'h000, 14'h040, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b1);
      vecs[7]  = mk("stall_src2",    1'b0, 1'b1, 4'b0100, pk(14'h000, 14'h000, 14'h080, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b1);
      vecs[8]  = mk("stall_hold1",   1'b0, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b1);
      vecs[9]  = mk("stall_hold2",   1'b0, 1'b0, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0001, 1'b1);
      vecs[10] = mk("consume_pend",  1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b1, 1'b0, 14'h0080, 1'b0);
      vecs[11] = mk("after_pend",    1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0081, 1'b0);
      vecs[12] = mk("prio_0_over_2", 1'b1, 1'b1, 4'b0101, pk(14'h100, 14'h000, 14'h200, 14'h000), 1'b0, 1'b1, 14'h0100, 1'b0);
      vecs[13] = mk("prio_1_of_3",   1'b1, 1'b1, 4'b1110, pk(14'h000, 14'h111, 14'h222, 14'h333), 1'b0, 1'b0, 14'h0111, 1'b0);
      vecs[14] = mk("stall_src3",    1'b0, 1'b0, 4'b1000, pk(14'h000, 14'h000, 14'h000, 14'h050), 1'b0, 1'b0, 14'h0111, 1'b1);
      vecs[15] = mk("cur_over_pend", 1'b1, 1'b1, 4'b0100, pk(14'h000, 14'h000, 14'h070, 14'h000), 1'b0, 1'b0, 14'h0070, 1'b0);
      vecs[16] = mk("pend_dropped",  1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0071, 1'b0);
      vecs[17] = mk("call_on_redir", 1'b1, 1'b1, 4'b0001, pk(14'h300, 14'h000, 14'h000, 14'h000), 1'b1, 1'b0, 14'h0300, 1'b0);
      vecs[18] = mk("idle",          1'b0, 1'b0, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0, 14'h0300, 1'b0);
      vecs[19] = mk("ret_empty",     1'b1, 1'b1, 4'b0000, pk(14'h000, 14'h000, 14'h000, 14'h000), 1'b0, 1'b1, 14'h0301, 1'b0);

      #12;
      check("reset.pc", bus.pc, 14'h0000);
      check("reset.pc_valid", bus.pc_valid, 1'b0);
      check("reset.pending", bus.redirect_pending, 1'b0);
      check("reset.ras_empty", bus.ras_empty, 1'b1);
      @(negedge CLK);
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].call, vecs[i].ret);
         step();
         check({vecs[i].name, ".pc"}, bus.pc, vecs[i].exp_pc);
         check({vecs[i].name, ".pending"}, bus.redirect_pending, vecs[i].exp_pend);
         check({vecs[i].name, ".ras_empty"}, bus.ras_empty, 1'b1);
         check({vecs[i].name, ".pc_valid"}, bus.pc_valid, 1'b1);
      end

`ifdef PC_SEQUENCER_RAS_EN
      jump("ras_to_10", 14'h010, 1'b1);
      adv("call_at_10", 1'b1, 1'b0, 14'h011, 1'b0);
      jump("jal_target", 14'h300, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         e = 14'h300 + 14'(k);
         adv("walk_callee", 1'b0, 1'b0, e, 1'b0);
      end
      drive(1'b1, 1'b1, 4'b0101, pk(14'h100, 14'h000, 14'h200, 14'h000), 1'b0, 1'b1);
      step();
      check("prio_ret.pc", bus.pc, 14'h100);
      check("prio_ret.ras_empty", bus.ras_empty, 1'b0);
      jump("back_to_305", 14'h305, 1'b0);
      adv("ret_at_305", 1'b0, 1'b1, 14'h011, 1'b1);
      adv("call_a", 1'b1, 1'b0, 14'h012, 1'b0);
      adv("call_ret_both", 1'b1, 1'b1, 14'h012, 1'b0);
      adv("ret_replaced", 1'b0, 1'b1, 14'h013, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         e = 14'h013 + 14'(k);
         adv("nest_call", 1'b1, 1'b0, e, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         e = 14'h01C - 14'(k);
         adv("nest_ret", 1'b0, 1'b1, e, (k == 7));
      end
      adv("ret_9th_lost", 1'b0, 1'b1, 14'h016, 1'b1);
      adv("call_pre_rst", 1'b1, 1'b0, 14'h017, 1'b0);
`else
      jump("noras_to_10", 14'h010, 1'b1);
      adv("noras_call", 1'b1, 1'b0, 14'h011, 1'b1);
      adv("noras_ret", 1'b0, 1'b1, 14'h012, 1'b1);
      adv("noras_both", 1'b1, 1'b1, 14'h013, 1'b1);
`endif

      drive(1'b0, 1'b1, 4'b0001, pk(14'h222, 14'h000, 14'h000, 14'h000), 1'b0, 1'b0);
      step();
      check("pre_rst.pending", bus.redirect_pending, 1'b1);
      check("pre_rst.pc_valid", bus.pc_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst.pc", bus.pc, 14'h0000);
      check("async_rst.pc_valid", bus.pc_valid, 1'b0);
      check("async_rst.pending", bus.redirect_pending, 1'b0);
      check("async_rst.ras_empty", bus.ras_empty, 1'b1);
      drive(1'b1, 1'b1, 4'b0000, pk(14'h0, 14'h0, 14'h0, 14'h0), 1'b0, 1'b0);
      @(negedge CLK);
      reset_n = 1'b1;
      step();
      check("post_rst.pc", bus.pc, 14'h0001);
      check("post_rst.pc_valid", bus.pc_valid, 1'b1);
      check("post_rst.pending", bus.redirect_pending, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
